ram_io_responder: RTL and testbench



---
 rtl/ram_io_pkg.sv | 20 ++
 rtl/ram_io_rdpipe.sv | 46 ++++
 rtl/ram_io_responder.sv | 118 +++++++++++
 tb/tb_ram_io_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_pkg.sv
// ram_io_pkg: field indices and FSM state shared by
// the RAM_IO memory-side responder and its read pipe.
package ram_io_pkg;

  localparam int C_VALID   = 0;
  localparam int C_WRITE   = 1;
  localparam int C_LOMASK  = 2;
  localparam int C_AUTOINC = 3;

  localparam int CFG_LAT = 0;
  localparam int CFG_WT  = 1;
  localparam int CFG_CLR = 2;
  localparam int CFG_DIS = 3;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

endpackage

// File: rtl/ram_io_rdpipe.sv
// ram_io_rdpipe: two-stage response delay line, each
// entry tagged with the latency it was issued with.
module ram_io_rdpipe #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_lat,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic          s0_v;
  logic          s0_lat;
  logic [DW-1:0] s0_d;
  logic          s1_v;
  logic [DW-1:0] s1_d;
  logic          s0_out;
  logic          s0_mv;

  // s1 is always older; a short entry colliding with it
  // slips into s1 so nothing is lost or reordered
  assign s0_out    = s0_v & ~s0_lat & ~s1_v;
  assign s0_mv     = s0_v & (s0_lat | s1_v);
  assign out_valid = s1_v | s0_out;
  assign out_data  = s1_v ? s1_d : s0_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v   <= 1'b0;
      s0_lat <= 1'b0;
      s0_d   <= '0;
      s1_v   <= 1'b0;
      s1_d   <= '0;
    end else begin
      s0_v   <= in_valid;
      s0_lat <= in_lat;
      s0_d   <= in_data;
      s1_v   <= s0_mv;
      s1_d   <= s0_d;
    end
  end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: memory-side responder for a RAM_IO
// tile with power-up/clear sweep and pipelined reads.
module ram_io_responder
  import ram_io_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = 16
) (
  input  logic          UserCLK,
  input  logic          resetn,
  input  logic [DW-1:0] FAB2RAM_D,
  input  logic [7:0]    FAB2RAM_A,
  input  logic [3:0]    FAB2RAM_C,
  input  logic [3:0]    Config_accessC,
  output logic [DW-1:0] RAM2FAB_D
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nx;
  logic [AW-1:0] ptr;
  logic          cfg_prev;
  logic [DW-1:0] mem [DEPTH];

  logic          clr_edge;
  logic          acc;
  logic          is_wr;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] wr_word;
  logic          pipe_v;
  logic [DW-1:0] pipe_d;
  logic          out_stb;
  logic [DW-1:0] out_d;

  assign clr_edge = Config_accessC[CFG_CLR] & ~cfg_prev;
  assign eff_addr = FAB2RAM_C[C_AUTOINC] ? ptr
                  : FAB2RAM_A[AW-1:0];
  assign rd_word  = mem[eff_addr];
  assign wr_word  = FAB2RAM_C[C_LOMASK]
                  ? {rd_word[DW-1:8], FAB2RAM_D[7:0]}
                  : FAB2RAM_D;
  assign is_wr    = FAB2RAM_C[C_WRITE];
  assign acc      = (state == ST_READY)
                  & FAB2RAM_C[C_VALID]
                  & ~Config_accessC[CFG_DIS]
                  & ~clr_edge;
  assign pipe_v   = acc & (~is_wr | Config_accessC[CFG_WT]);
  assign pipe_d   = is_wr ? wr_word : rd_word;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_INIT: begin
        cnt_nx = cnt + AW'(1);
        if (cnt == LAST) begin
          state_nx = ST_READY;
          cnt_nx   = '0;
        end
      end
      ST_READY: begin
        if (clr_edge) begin
          state_nx = ST_INIT;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_INIT;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_INIT;
      cnt       <= '0;
      ptr       <= '0;
      cfg_prev  <= 1'b0;
      RAM2FAB_D <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cfg_prev <= Config_accessC[CFG_CLR];
      if (acc)
        ptr <= (eff_addr == LAST) ? '0
             : eff_addr + AW'(1);
      if (out_stb)
        RAM2FAB_D <= out_d;
    end
  end

  // array carries no reset; the INIT sweep defines it
  always_ff @(posedge UserCLK) begin
    if (state == ST_INIT)
      mem[cnt] <= '0;
    else if (acc && is_wr)
      mem[eff_addr] <= wr_word;
  end

  ram_io_rdpipe #(
    .DW(DW)
  ) u_rdpipe (
    .clk      (UserCLK),
    .rst_n    (resetn),
    .in_valid (pipe_v),
    .in_lat   (Config_accessC[CFG_LAT]),
    .in_data  (pipe_d),
    .out_valid(out_stb),
    .out_data (out_d)
  );

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: scoreboard bench for the RAM_IO
// responder; one task per feature.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] d = '0;
  logic [7:0]  a = '0;
  logic [3:0]  c = '0;
  logic [3:0]  cfg = 4'b0010;
  logic [15:0] q;

  int ntest = 0;
  int nfail = 0;
  int edges = 0;

  typedef struct {
    logic [15:0] d;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [3:0] IDLE = 4'b0000;
  localparam logic [3:0] RD   = 4'b0001;
  localparam logic [3:0] WR   = 4'b0011;
  localparam logic [3:0] WRLO = 4'b0111;
  localparam logic [3:0] RDAI = 4'b1001;

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  ram_io_responder dut (
    .UserCLK       (clk),
    .resetn        (rst_n),
    .FAB2RAM_D     (d),
    .FAB2RAM_A     (a),
    .FAB2RAM_C     (c),
    .Config_accessC(cfg),
    .RAM2FAB_D     (q)
  );

  // scoreboard: pop when the entry's update edge has passed
  always @(negedge clk) begin
    if (rst_n && sb.size() != 0 && sb[0].due == edges) begin
      mon_e = sb.pop_front();
      ntest++;
      if (q !== mon_e.d) begin
        nfail++;
        $display("FAIL %s got %h want %h", mon_e.tag, q, mon_e.d);
      end
    end
  end

  task automatic drive(input logic [3:0] cc,
                       input logic [7:0] aa,
                       input logic [15:0] dd);
    c = cc;
    a = aa;
    d = dd;
  endtask

  task automatic push(input logic [15:0] v, input string tag);
    exp_t e;
    e.d   = v;
    e.due = edges + 2 + int'(cfg[0]);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    cfg   = 4'b0010;
    drive(IDLE, 8'h00, 16'h0000);
    repeat (2) @(negedge clk);
    ntest++;
    if (q !== 16'h0000) begin
      nfail++;
      $display("FAIL reset_q got %h want 0000", q);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      drive(WR, 8'h10, 16'h5A5A);
      @(negedge clk);
      if (q !== 16'h0000) bad++;
    end
    ntest++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL init_ignore got %0d echoes want 0", bad);
    end
    drive(RD, 8'h10, 16'h0000);
    push(16'h0000, "first_read");
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    cfg = 4'b0000;
    drive(WR, 8'h05, 16'hBEEF);
    @(negedge clk);
    drive(RD, 8'h05, 16'h0000);
    push(16'hBEEF, "lat0");
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    ntest++;
    if (q !== 16'h0000) begin
      nfail++;
      $display("FAIL lat0_early got %h want 0000", q);
    end
    repeat (2) @(negedge clk);
    cfg = 4'b0001;
    drive(WR, 8'h05, 16'h5EED);
    @(negedge clk);
    drive(RD, 8'h05, 16'h0000);
    push(16'h5EED, "lat1");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(IDLE, 8'h00, 16'h0000);
      ntest++;
      if (q !== 16'hBEEF) begin
        nfail++;
        $display("FAIL lat1_early%0d got %h want beef", i, q);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pat;
    logic [15:0] prev;
    logic [15:0] ev;
    logic [15:0] exq[$];
    int          got;
    pat = 8'b1010_0110;
    cfg = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      drive(WR, 8'(8'h40 + i), 16'(16'h7100 + i));
      @(negedge clk);
    end
    prev = q;
    got  = 0;
    for (int i = 0; i < 28; i++) begin
      if (i < 8) begin
        cfg[0] = pat[i];
        drive(RD, 8'(8'h40 + i), 16'h0000);
        exq.push_back(16'(16'h7100 + i));
      end else begin
        drive(IDLE, 8'h00, 16'h0000);
      end
      @(negedge clk);
      if (q !== prev) begin
        ntest++;
        got++;
        if (exq.size() == 0) begin
          nfail++;
          $display("FAIL b2b_extra got %h want none", q);
        end else begin
          ev = exq.pop_front();
          if (q !== ev) begin
            nfail++;
            $display("FAIL b2b_order got %h want %h", q, ev);
          end
        end
        prev = q;
      end
    end
    ntest++;
    if (got != 8) begin
      nfail++;
      $display("FAIL b2b_count got %0d want 8", got);
    end
  endtask

  task automatic test_autoinc();
    cfg = 4'b0000;
    drive(WR, 8'hFE, 16'h10FE); @(negedge clk);
    drive(WR, 8'hFF, 16'h11FF); @(negedge clk);
    drive(WR, 8'h00, 16'h2200); @(negedge clk);
    drive(WR, 8'h01, 16'h3301); @(negedge clk);
    drive(RD, 8'hFE, 16'h0000);
    push(16'h10FE, "ai_base");
    @(negedge clk);
    drive(RDAI, 8'h77, 16'h0000);
    push(16'h11FF, "ai_ff");
    @(negedge clk);
    drive(RDAI, 8'h77, 16'h0000);
    push(16'h2200, "ai_wrap00");
    @(negedge clk);
    drive(RDAI, 8'h77, 16'h0000);
    push(16'h3301, "ai_01");
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mask();
    cfg = 4'b0010;
    drive(WR, 8'h20, 16'hABCD);
    push(16'hABCD, "wt_full");
    @(negedge clk);
    drive(WRLO, 8'h20, 16'h1234);
    push(16'hAB34, "wt_lomask");
    @(negedge clk);
    drive(RD, 8'h20, 16'h0000);
    push(16'hAB34, "rd_lomask");
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear();
    int bad;
    cfg = 4'b0110;
    drive(WR, 8'h20, 16'hFFFF);
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      drive(RD, 8'h20, 16'h0000);
      @(negedge clk);
      if (q !== 16'hAB34) bad++;
    end
    ntest++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL clr_hold got %0d changes want 0", bad);
    end
    drive(WR, 8'h20, 16'h2468);
    push(16'h2468, "clr_boundary");
    @(negedge clk);
    drive(RD, 8'h05, 16'h0000);
    push(16'h0000, "clr_zero");
    @(negedge clk);
    drive(RD, 8'h20, 16'h0000);
    push(16'h2468, "clr_rd");
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    cfg = 4'b0010;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_disable();
    cfg = 4'b0011;
    drive(WR, 8'h30, 16'h7777);
    push(16'h7777, "dis_inflight");
    @(negedge clk);
    cfg = 4'b1011;
    drive(WR, 8'h30, 16'h9999);
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    repeat (5) @(negedge clk);
    ntest++;
    if (q !== 16'h7777) begin
      nfail++;
      $display("FAIL dis_hold got %h want 7777", q);
    end
    cfg = 4'b0000;
    drive(RD, 8'h30, 16'h0000);
    push(16'h7777, "dis_dropped_wr");
    @(negedge clk);
    drive(IDLE, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cfg = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      drive(WR, 8'(8'h31 + i), 16'(16'h1111 * (i + 1)));
      push(16'(16'h1111 * (i + 1)), "burst");
      @(negedge clk);
    end
    drive(IDLE, 8'h00, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    ntest++;
    if (q !== 16'h0000) begin
      nfail++;
      $display("FAIL async_reset got %h want 0000", q);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ntest++;
    if (q !== 16'h0000) begin
      nfail++;
      $display("FAIL reset_pipe got %h want 0000", q);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_autoinc();
    test_mask();
    test_clear();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
